// File: rtl/ssd_pkg.sv
// ssd_pkg
// Shared definitions for the scanned seven-segment display driver.
// Contents:
//   SEG_BLANK / SEG_DASH - active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   state_e              - encoding of the conversion FSM
//   seg_of()             - decimal digit to active-low segment pattern
//   bcd_nibbles()        - BCD nibbles needed for a binary width, ceil(w*0.302)+1
//   max_value()          - largest value that fits in a number of decimal digits
package ssd_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Common-anode patterns: a 0 lights the segment.
   function automatic logic [6:0] seg_of(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Integer form of ceil(w*0.302)+1; the +1 guarantees the accumulator
   // never truncates during the add-3 / shift sequence.
   function automatic int bcd_nibbles(input int w);
      return (w * 302 + 999) / 1000 + 1;
   endfunction

   function automatic logic [63:0] max_value(input int digits);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < digits; i++) begin
         r = r * 64'd10;
      end
      return r - 64'd1;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential double-dabble converter with a one-deep pending slot.
// Ports:
//   clk_i, rst_ni      - clock, asynchronous active-low reset
//   value_i, load_i    - binary value and conversion request
//   bcd_o              - committed BCD digits (display register), DIGITS nibbles
//   busy_o             - high while shifting and during the commit cycle
//   bcd_valid_o        - one-cycle pulse in the commit (DONE) cycle
//   overflow_o         - last committed value exceeded 10^DIGITS-1
module bin2bcd_seq
   import ssd_pkg::*;
#(
   parameter int BIN_W  = 13,
   parameter int DIGITS = 4
)(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [BIN_W-1:0]      value_i,
   input  logic                  load_i,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic                  busy_o,
   output logic                  bcd_valid_o,
   output logic                  overflow_o
);

   localparam int NIB   = bcd_nibbles(BIN_W);
   // Accumulator is at least DIGITS nibbles so the commit slice is always legal.
   localparam int ACC_N = (NIB > DIGITS) ? NIB : DIGITS;
   localparam int ACC_W = 4 * ACC_N;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [63:0] MAXV = max_value(DIGITS);

   state_e                  state_q;
   logic [ACC_W+BIN_W-1:0]  sr_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    pend_q;
   logic [BIN_W-1:0]        pend_val_q;
   logic                    ovf_cap_q;
   logic [4*DIGITS-1:0]     bcd_q;
   logic                    busy_q;
   logic                    valid_q;
   logic                    ovf_q;

   logic [ACC_W-1:0]        acc_adj;
   logic [ACC_W+BIN_W-1:0]  sr_d;
   logic [BIN_W-1:0]        src_d;

   // Add-3 correction on every nibble before the shift.
   for (genvar gi = 0; gi < ACC_N; gi++) begin : g_dabble
      assign acc_adj[4*gi +: 4] = (sr_q[BIN_W+4*gi +: 4] >= 4'd5)
                                ? sr_q[BIN_W+4*gi +: 4] + 4'd3
                                : sr_q[BIN_W+4*gi +: 4];
   end

   assign sr_d = {acc_adj, sr_q[BIN_W-1:0]} << 1;

   // A fresh load beats the pending slot when restarting straight from DONE.
   assign src_d = (state_q == ST_DONE && !load_i) ? pend_val_q : value_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         sr_q       <= '0;
         cnt_q      <= '0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         ovf_cap_q  <= 1'b0;
         bcd_q      <= '0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               valid_q <= 1'b0;
               if (load_i) begin
                  sr_q      <= {{ACC_W{1'b0}}, src_d};
                  cnt_q     <= CNT_W'(BIN_W);
                  ovf_cap_q <= (64'(src_d) > MAXV);
                  busy_q    <= 1'b1;
                  state_q   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               sr_q  <= sr_d;
               cnt_q <= cnt_q - 1'b1;
               if (load_i) begin
                  pend_q     <= 1'b1;
                  pend_val_q <= value_i;
               end
               if (cnt_q == CNT_W'(1)) begin
                  // Last shift: commit straight from the shifted result.
                  bcd_q   <= sr_d[BIN_W +: 4*DIGITS];
                  ovf_q   <= ovf_cap_q;
                  valid_q <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               valid_q <= 1'b0;
               pend_q  <= 1'b0;
               if (load_i || pend_q) begin
                  sr_q      <= {{ACC_W{1'b0}}, src_d};
                  cnt_q     <= CNT_W'(BIN_W);
                  ovf_cap_q <= (64'(src_d) > MAXV);
                  state_q   <= ST_SHIFT;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bcd_o       = bcd_q;
   assign busy_o      = busy_q;
   assign bcd_valid_o = valid_q;
   assign overflow_o  = ovf_q;

endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver
// Converts a binary value to decimal and scans it onto DIGITS common-anode digits.
// Ports:
//   clk_i, rst_ni            - clock, asynchronous active-low reset
//   value_i, load_i          - value to display and its load strobe
//   blank_lz_i               - blank leading zero digits (digit 0 always shown)
//   busy_o, bcd_valid_o      - converter status, commit pulse
//   overflow_o               - committed value too large; all digits show a dash
//   anode_o                  - active-low one-hot digit enables, digit 0 = LSD
//   seg_o                    - active-low segments {g,f,e,d,c,b,a}
//   dp_o                     - decimal point, held off (1)
module ssd_scan_driver
   import ssd_pkg::*;
#(
   parameter int BIN_W       = 13,
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 100000
)(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [BIN_W-1:0]   value_i,
   input  logic               load_i,
   input  logic               blank_lz_i,
   output logic               busy_o,
   output logic               bcd_valid_o,
   output logic               overflow_o,
   output logic [DIGITS-1:0]  anode_o,
   output logic [6:0]         seg_o,
   output logic               dp_o
);

   localparam int RC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [4*DIGITS-1:0] disp;
   logic                ovf;
   logic [RC_W-1:0]     rcnt_q;
   logic [IDX_W-1:0]    idx_q;
   logic [DIGITS-1:0]   anode_q;
   logic [DIGITS-1:0]   anode_d;
   logic [6:0]          seg_q;
   logic [6:0]          seg_d;
   logic [3:0]          nib;
   logic [DIGITS-1:0]   keep;

   bin2bcd_seq #(
      .BIN_W  (BIN_W),
      .DIGITS (DIGITS)
   ) u_conv (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .value_i     (value_i),
      .load_i      (load_i),
      .bcd_o       (disp),
      .busy_o      (busy_o),
      .bcd_valid_o (bcd_valid_o),
      .overflow_o  (ovf)
   );

   // keep[i]: digit i or something above it is nonzero, so digit i is not a leading zero.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_keep
      if (gi == 0) begin : g_lsd
         assign keep[gi] = 1'b1;
      end else begin : g_upper
         assign keep[gi] = |disp[4*DIGITS-1:4*gi];
      end
   end

   always_comb begin
      nib     = disp[4*idx_q +: 4];
      anode_d = ~(DIGITS'(1) << idx_q);
      seg_d   = seg_of(nib);
      if (ovf) begin
         seg_d = SEG_DASH;
      end else if (blank_lz_i && !keep[idx_q]) begin
         seg_d = SEG_BLANK;
      end
   end

   // Refresh counter and digit index; anode/seg are registered from the
   // pre-edge index so both change together on a digit switch.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rcnt_q  <= '0;
         idx_q   <= '0;
         anode_q <= '1;
         seg_q   <= SEG_BLANK;
      end else begin
         anode_q <= anode_d;
         seg_q   <= seg_d;
         if (rcnt_q == RC_W'(REFRESH_DIV - 1)) begin
            rcnt_q <= '0;
            idx_q  <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
         end else begin
            rcnt_q <= rcnt_q + 1'b1;
         end
      end
   end

   assign anode_o    = anode_q;
   assign seg_o      = seg_q;
   assign overflow_o = ovf;
   assign dp_o       = 1'b1;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver
// Directed bench for ssd_scan_driver (BIN_W=14, DIGITS=4, REFRESH_DIV=4) with an
// arithmetic reference model compared every cycle plus literal spot checks.
module tb_ssd_scan_driver;

   localparam int BW = 14;
   localparam int D  = 4;
   localparam int R  = 4;

   logic          clk;
   logic          rst_ni;
   logic [BW-1:0] value;
   logic          load;
   logic          blank_lz;
   logic          busy, bcd_valid, overflow, dp;
   logic [D-1:0]  anode;
   logic [6:0]    seg;

   int n_checks = 0;
   int n_fail   = 0;

   ssd_scan_driver #(.BIN_W(BW), .DIGITS(D), .REFRESH_DIV(R)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .value_i     (value),
      .load_i      (load),
      .blank_lz_i  (blank_lz),
      .busy_o      (busy),
      .bcd_valid_o (bcd_valid),
      .overflow_o  (overflow),
      .anode_o     (anode),
      .seg_o       (seg),
      .dp_o        (dp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [6:0] segtab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   int p10 [0:D] = '{1, 10, 100, 1000, 10000};

   int  m_edge, m_disp, m_job, m_fin, m_pend_v;
   bit  m_ovf, m_active, m_valid, m_pend;
   logic [D-1:0] e_anode;
   logic [6:0]   e_seg;
   bit  e_busy, e_valid, e_ovf;

   function automatic logic [6:0] exp_seg(input int idx, input int disp, input bit ovf, input bit blz);
      int dig;
      dig = (disp / p10[idx]) % 10;
      if (ovf) return 7'h3F;
      if (blz && idx > 0 && disp < p10[idx]) return 7'h7F;
      return segtab[dig];
   endfunction

   task automatic m_reset();
      m_edge = 0; m_disp = 0; m_job = 0; m_fin = 0; m_pend_v = 0;
      m_ovf = 0; m_active = 0; m_valid = 0; m_pend = 0;
      e_anode = '1; e_seg = 7'h7F; e_busy = 0; e_valid = 0; e_ovf = 0;
   endtask

   initial begin
      bit start;
      int sv;
      int idx;
      m_reset();
      forever begin
         @(posedge clk or negedge rst_ni);
         if (!rst_ni) begin
            m_reset();
         end else begin
            idx     = (m_edge / R) % D;
            e_anode = ~(D'(1) << idx);
            e_seg   = exp_seg(idx, m_disp, m_ovf, blank_lz);
            m_edge++;
            start = 0;
            sv    = 0;
            if (m_valid) begin
               m_valid = 0;
               if (load) begin
                  start = 1; sv = int'(value);
               end else if (m_pend) begin
                  start = 1; sv = m_pend_v;
               end
               m_pend = 0;
            end else if (m_active) begin
               if (load) begin
                  m_pend = 1; m_pend_v = int'(value);
               end
               if (m_edge == m_fin) begin
                  m_active = 0;
                  m_valid  = 1;
                  m_disp   = m_job % p10[D];
                  m_ovf    = (m_job > p10[D] - 1);
               end
            end else if (load) begin
               start = 1; sv = int'(value);
            end
            if (start) begin
               m_active = 1;
               m_job    = sv;
               m_fin    = m_edge + BW;
            end
            e_busy  = m_active || m_valid;
            e_valid = m_valid;
            e_ovf   = m_ovf;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("busy",      32'(busy),      32'(e_busy));
      chk("bcd_valid", 32'(bcd_valid), 32'(e_valid));
      chk("overflow",  32'(overflow),  32'(e_ovf));
      chk("anode",     32'(anode),     32'(e_anode));
      chk("seg",       32'(seg),       32'(e_seg));
      chk("dp",        32'(dp),        32'd1);
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_load(input int v);
      @(negedge clk);
      value = BW'(v);
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
   endtask

   task automatic check_digit(input int idx, input logic [6:0] want);
      logic [D-1:0] an;
      bit found;
      an    = ~(D'(1) << idx);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (anode == an) begin
            found = 1;
            chk($sformatf("digit%0d_seg", idx), 32'(seg), 32'(want));
         end
      end
      if (!found) chk($sformatf("digit%0d_seen", idx), 32'd0, 32'd1);
   endtask

   task automatic check_all(input logic [6:0] w3, input logic [6:0] w2,
                            input logic [6:0] w1, input logic [6:0] w0);
      check_digit(0, w0);
      check_digit(1, w1);
      check_digit(2, w2);
      check_digit(3, w3);
   endtask

   // Waits for the current conversion to finish and the display to settle.
   task automatic wait_idle();
      for (int i = 0; i < 100 && busy; i++) @(negedge clk);
      chk("idle_reached", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int lat, nbusy, npulse, first_t, gap;
      bit seen;
      rst_ni = 1'b0; value = '0; load = 1'b0; blank_lz = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_anode", 32'(anode), 32'hF);
      chk("reset_seg",   32'(seg),   32'h7F);
      rst_ni = 1'b1;
      @(negedge clk);
      chk("first_anode", 32'(anode), 32'hE);
      chk("first_seg",   32'(seg),   32'h40);
      repeat (39) @(negedge clk);
      check_all(7'h40, 7'h40, 7'h40, 7'h40);

      // 1234: latency and busy width are BIN_W+1 = 15 samples
      @(negedge clk);
      value = BW'(1234); load = 1'b1;
      lat = 0; nbusy = 0; seen = 0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(negedge clk);
         load = 1'b0;
         if (busy) nbusy++;
         if (bcd_valid) begin seen = 1; lat = i; end
      end
      chk("latency_1234", 32'(lat),   32'd15);
      chk("busy_len",     32'(nbusy), 32'd15);
      wait_idle();
      check_all(7'h79, 7'h24, 7'h30, 7'h19);
      chk("ovf_1234", 32'(overflow), 32'd0);

      do_load(8191);  wait_idle(); check_all(7'h00, 7'h79, 7'h10, 7'h79);
      do_load(9999);  wait_idle(); check_all(7'h10, 7'h10, 7'h10, 7'h10);
      chk("ovf_9999", 32'(overflow), 32'd0);
      do_load(10000); wait_idle(); check_all(7'h3F, 7'h3F, 7'h3F, 7'h3F);
      chk("ovf_10000", 32'(overflow), 32'd1);

      blank_lz = 1'b1;
      do_load(7); wait_idle(); check_all(7'h7F, 7'h7F, 7'h7F, 7'h78);
      do_load(0); wait_idle(); check_all(7'h7F, 7'h7F, 7'h7F, 7'h40);

      // pending slot: 5 is overwritten by 42 before the 1234 commit
      blank_lz = 1'b0;
      do_load(1234);
      repeat (3) @(negedge clk);
      do_load(5);
      repeat (2) @(negedge clk);
      do_load(42);
      npulse = 0; first_t = 0; gap = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bcd_valid) begin
            if (npulse == 0) first_t = i;
            else if (npulse == 1) gap = i - first_t;
            npulse++;
         end
      end
      chk("pend_pulses", 32'(npulse), 32'd2);
      chk("pend_gap",    32'(gap),    32'd15);
      check_all(7'h40, 7'h40, 7'h19, 7'h24);

      // reset in mid-conversion
      do_load(4321);
      repeat (5) @(negedge clk);
      #1 rst_ni = 1'b0;
      #1;
      chk("midrst_busy",  32'(busy),  32'd0);
      chk("midrst_anode", 32'(anode), 32'hF);
      chk("midrst_seg",   32'(seg),   32'h7F);
      @(negedge clk);
      rst_ni = 1'b1;
      repeat (30) @(negedge clk);
      check_all(7'h40, 7'h40, 7'h40, 7'h40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
